// File: rtl/io_port_pkg.sv
// Shared address map, STATUS bit positions and FSM state types for io_port_ctrl.
package io_port_pkg;

    localparam logic [4:0] OUT_BASE    = 5'd0;
    localparam logic [4:0] IN_BASE     = 5'd8;
    localparam logic [4:0] ADDR_STATUS = 5'd16;
    localparam logic [4:0] ADDR_TX     = 5'd17;
    localparam logic [4:0] ADDR_RX     = 5'd18;

    localparam int unsigned ST_TX_BUSY = 0;
    localparam int unsigned ST_RX_FULL = 1;
    localparam int unsigned ST_TX_OVF  = 2;
    localparam int unsigned ST_RX_OVR  = 3;

    // Consecutive FULL+rx_valid cycles that flag an overrun
    localparam int unsigned OVR_LIMIT = 16;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic {RX_EMPTY, RX_FULL} rx_state_e;

endpackage

// File: rtl/io_sync.sv
// Multi-stage flip-flop synchroniser for a bus of asynchronous inputs.
module io_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O controller: output latches, synchronised inputs,
// and a TX/RX channel with valid/ready handshakes and a status register.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   dirport,
    input  logic [15:0]  outport,
    input  logic         we,
    output logic [15:0]  inport,
    input  logic [127:0] pin_in,
    output logic [127:0] pout,
    output logic [15:0]  tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [15:0]  rx_data,
    input  logic         rx_valid,
    output logic         rx_ready
);

    logic [15:0]  lat_q [8];
    logic [127:0] pin_sync;
    tx_state_e    tx_state_q;
    rx_state_e    rx_state_q;
    logic [15:0]  tx_data_q, rx_data_q;
    logic         tx_ovf_q, rx_ovr_q;
    logic [3:0]   ovr_cnt_q;
    logic [15:0]  status;
    logic         wr_out, wr_status, wr_tx, wr_rx;

    assign wr_out    = we && (dirport[4:3] == OUT_BASE[4:3]);
    assign wr_status = we && (dirport == ADDR_STATUS);
    assign wr_tx     = we && (dirport == ADDR_TX);
    assign wr_rx     = we && (dirport == ADDR_RX);

    io_sync #(.STAGES(SYNC_STAGES), .WIDTH(128)) u_sync (
        .clk_i   (clk),
        .reset_i (reset),
        .d_i     (pin_in),
        .q_o     (pin_sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < 8; k++) lat_q[k] <= '0;
        end else if (wr_out) begin
            lat_q[dirport[2:0]] <= outport;
        end
    end

    always_comb begin
        pout = '0;
        for (int unsigned k = 0; k < 8; k++) pout[16*k +: 16] = lat_q[k];
    end

    // A TXDATA write while SEND is dropped, even on the handshake edge
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_data_q  <= '0;
            tx_ovf_q   <= 1'b0;
        end else begin
            if (wr_status && outport[ST_TX_OVF]) tx_ovf_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (wr_tx) begin
                        tx_data_q  <= outport;
                        tx_state_q <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_ready) tx_state_q <= TX_IDLE;
                    if (wr_tx)    tx_ovf_q   <= 1'b1;
                end
            endcase
        end
    end

    assign tx_valid = (tx_state_q == TX_SEND);
    assign tx_data  = tx_data_q;

    // Overrun counter saturates, so a stall that persists re-flags after a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_EMPTY;
            rx_data_q  <= '0;
            rx_ovr_q   <= 1'b0;
            ovr_cnt_q  <= '0;
        end else begin
            if (wr_status && outport[ST_RX_OVR]) rx_ovr_q <= 1'b0;
            case (rx_state_q)
                RX_EMPTY: begin
                    ovr_cnt_q <= '0;
                    if (rx_valid) begin
                        rx_data_q  <= rx_data;
                        rx_state_q <= RX_FULL;
                    end
                end
                RX_FULL: begin
                    if (rx_valid) begin
                        if (ovr_cnt_q == 4'(OVR_LIMIT - 1)) rx_ovr_q <= 1'b1;
                        else                                ovr_cnt_q <= ovr_cnt_q + 4'd1;
                    end else begin
                        ovr_cnt_q <= '0;
                    end
                    if (wr_rx) rx_state_q <= RX_EMPTY;
                end
            endcase
        end
    end

    assign rx_ready = (rx_state_q == RX_EMPTY) && !reset;

    always_comb begin
        status              = '0;
        status[ST_TX_BUSY]  = tx_valid;
        status[ST_RX_FULL]  = (rx_state_q == RX_FULL);
        status[ST_TX_OVF]   = tx_ovf_q;
        status[ST_RX_OVR]   = rx_ovr_q;
    end

    always_comb begin
        inport = '0;
        if (dirport[4:3] == OUT_BASE[4:3])     inport = lat_q[dirport[2:0]];
        else if (dirport[4:3] == IN_BASE[4:3]) inport = pin_sync[{dirport[2:0], 4'b0000} +: 16];
        else if (dirport == ADDR_STATUS)       inport = status;
        else if (dirport == ADDR_RX)           inport = rx_data_q;
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: vector table, directed corner sequences, random vs model.
module tb_io_port_ctrl;

    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   dirport;
    logic [15:0]  outport;
    logic         we;
    logic [15:0]  inport;
    logic [127:0] pin_in;
    logic [127:0] pout;
    logic [15:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [15:0]  rx_data;
    logic         rx_valid;
    logic         rx_ready;

    always #5 clk = ~clk;

    io_port_ctrl #(.SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .dirport(dirport), .outport(outport), .we(we),
        .inport(inport), .pin_in(pin_in), .pout(pout), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural reference: architectural state described directly by the port rules
    logic [15:0]  m_lat [8];
    logic [127:0] m_hist [SS];   // pin_in as sampled at past edges, [0] newest
    bit           m_txv, m_ovf, m_full, m_ovr;
    logic [15:0]  m_txd, m_rxw;
    int           m_streak;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        return {12'h000, m_ovr, m_ovf, m_full, m_txv};
    endfunction

    function automatic logic [15:0] m_read(input logic [4:0] a);
        if (a < 8)   return m_lat[a[2:0]];
        if (a < 16)  return m_hist[SS-1][16*a[2:0] +: 16];
        if (a == 16) return m_status();
        if (a == 18) return m_rxw;
        return 16'h0000;
    endfunction

    function automatic logic [127:0] m_pout();
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[16*k +: 16] = m_lat[k];
        return r;
    endfunction

    task automatic model_edge();
        bit nv;
        if (reset) begin
            for (int k = 0; k < 8; k++) m_lat[k] = '0;
            for (int k = 0; k < SS; k++) m_hist[k] = '0;
            m_txv = 0; m_ovf = 0; m_full = 0; m_ovr = 0;
            m_txd = '0; m_rxw = '0; m_streak = 0;
        end else begin
            if (we && dirport == 16 && outport[2]) m_ovf = 0;
            nv = m_txv && !tx_ready;
            if (we && dirport == 17) begin
                if (m_txv) m_ovf = 1;
                else begin m_txd = outport; nv = 1; end
            end
            m_txv = nv;
            if (m_full && rx_valid) m_streak++; else m_streak = 0;
            if (we && dirport == 16 && outport[3]) m_ovr = 0;
            if (m_streak >= 16) m_ovr = 1;
            if (!m_full) begin
                if (rx_valid) begin m_rxw = rx_data; m_full = 1; end
            end else if (we && dirport == 18) m_full = 0;
            if (we && dirport < 8) m_lat[dirport[2:0]] = outport;
            for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = pin_in;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        dirport = a; outport = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [15:0] exp);
        dirport = a;
        #1;
        chk(name, inport, exp);
    endtask

    task automatic check_all();
        chk("rnd_pout", pout, m_pout());
        chk("rnd_tx_valid", tx_valid, m_txv);
        chk("rnd_tx_data", tx_data, m_txd);
        chk("rnd_rx_ready", rx_ready, !m_full && !reset);
        chk("rnd_inport", inport, m_read(dirport));
    endtask

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
        logic        w;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int vprob;
        tbl[0] = '{5'd3,  16'hBEEF, 1'b1, 16'hBEEF};
        tbl[1] = '{5'd25, 16'h1234, 1'b1, 16'h0000};
        tbl[2] = '{5'd0,  16'hFFFF, 1'b1, 16'hFFFF};
        tbl[3] = '{5'd7,  16'h0001, 1'b1, 16'h0001};
        tbl[4] = '{5'd3,  16'h0000, 1'b0, 16'hBEEF};
        tbl[5] = '{5'd19, 16'hAAAA, 1'b1, 16'h0000};
        tbl[6] = '{5'd31, 16'h5555, 1'b1, 16'h0000};
        tbl[7] = '{5'd5,  16'h8001, 1'b1, 16'h8001};

        reset = 1'b1; we = 1'b0; dirport = '0; outport = '0; pin_in = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        tick(); tick();
        chk("rst_pout", pout, '0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("rx_ready_after_rst", rx_ready, 1'b1);
        rd_chk("rst_status", 5'd16, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            dirport = tbl[i].a; outport = tbl[i].d; we = tbl[i].w;
            tick();
            we = 1'b0;
            rd_chk("tbl_read", tbl[i].a, tbl[i].exp);
            if (tbl[i].a < 8) chk("tbl_pout_slice", pout[16*tbl[i].a[2:0] +: 16], tbl[i].exp);
            chk("tbl_pout", pout, m_pout());
        end
        chk("latch3_pout", pout[63:48], 16'hBEEF);
        rd_chk("latch3_read", 5'd3, 16'hBEEF);

        pin_in[95:80] = 16'h1234;
        rd_chk("sync_t0", 5'd13, 16'h0000);
        tick();
        rd_chk("sync_t1", 5'd13, 16'h0000);
        tick();
        rd_chk("sync_t2", 5'd13, 16'h1234);

        wr(5'd17, 16'h00A5);
        for (int i = 0; i < 4; i++) begin
            chk("tx_hold_valid", tx_valid, 1'b1);
            chk("tx_hold_data", tx_data, 16'h00A5);
            tick();
        end
        wr(5'd17, 16'h1111);
        rd_chk("tx_ovf_status", 5'd16, 16'h0005);
        chk("tx_ovf_data_kept", tx_data, 16'h00A5);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        chk("tx_handshake", tx_valid, 1'b0);
        wr(5'd16, 16'h0004);
        rd_chk("tx_ovf_clear", 5'd16, 16'h0000);

        wr(5'd17, 16'h0BAD);
        dirport = 5'd17; outport = 16'hC0DE; we = 1'b1; tx_ready = 1'b1;
        tick();
        we = 1'b0; tx_ready = 1'b0;
        chk("tx_hs_write_valid", tx_valid, 1'b0);
        chk("tx_hs_write_data", tx_data, 16'h0BAD);
        rd_chk("tx_hs_write_status", 5'd16, 16'h0004);
        wr(5'd17, 16'h0C0D);
        chk("tx_b2b_valid", tx_valid, 1'b1);
        chk("tx_b2b_data", tx_data, 16'h0C0D);
        rd_chk("tx_b2b_status", 5'd16, 16'h0005);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        wr(5'd16, 16'h0004);
        rd_chk("tx_idle_status", 5'd16, 16'h0000);

        rx_data = 16'h7E01; rx_valid = 1'b1;
        tick();
        rx_data = 16'hFFFF;
        #1;
        chk("rx_cap_ready", rx_ready, 1'b0);
        rd_chk("rx_cap_status", 5'd16, 16'h0002);
        rd_chk("rx_cap_data", 5'd18, 16'h7E01);
        repeat (15) tick();
        rd_chk("rx_ovr_15", 5'd16, 16'h0002);
        tick();
        rd_chk("rx_ovr_16", 5'd16, 16'h000A);
        rd_chk("rx_word_kept", 5'd18, 16'h7E01);
        rx_valid = 1'b0;
        wr(5'd18, 16'h0000);
        chk("rx_ack_ready", rx_ready, 1'b1);
        rd_chk("rx_ack_status", 5'd16, 16'h0008);
        wr(5'd16, 16'h0008);
        rd_chk("rx_ovr_clear", 5'd16, 16'h0000);

        rx_data = 16'h1357; rx_valid = 1'b1;
        tick();
        rx_data = 16'h2468; dirport = 5'd18; we = 1'b1;
        tick();
        we = 1'b0;
        chk("rx_simul_empty", rx_ready, 1'b1);
        rd_chk("rx_simul_status", 5'd16, 16'h0000);
        tick();
        rx_valid = 1'b0;
        rd_chk("rx_simul_recapture", 5'd18, 16'h2468);
        chk("rx_simul_full", rx_ready, 1'b0);
        wr(5'd18, 16'h0000);
        wr(5'd18, 16'h0000);
        chk("rx_empty_ack_ready", rx_ready, 1'b1);
        rd_chk("rx_empty_ack_status", 5'd16, 16'h0000);

        wr(5'd2, 16'h4321);
        wr(5'd17, 16'h00FF);
        rx_data = 16'h9999; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        chk("pre_rst_rx_ready", rx_ready, 1'b0);
        reset = 1'b1;
        tick();
        chk("mid_rst_tx_valid", tx_valid, 1'b0);
        chk("mid_rst_pout", pout, '0);
        chk("mid_rst_rx_ready", rx_ready, 1'b0);
        rd_chk("mid_rst_status", 5'd16, 16'h0000);
        reset = 1'b0;
        #1;
        chk("post_rst_rx_ready", rx_ready, 1'b1);
        rd_chk("post_rst_rxdata", 5'd18, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            vprob = ((i / 250) % 2 == 1) ? 97 : 50;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) dirport = 5'(16 + $urandom_range(0, 2));
            else                           dirport = 5'($urandom_range(0, 31));
            outport  = 16'($urandom());
            we       = ($urandom_range(0, 2) == 0);
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = ($urandom_range(0, 99) < vprob);
            rx_data  = 16'($urandom());
            if ($urandom_range(0, 7) == 0) pin_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            check_all();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
